// File: rtl/pll_gate_driver.sv
// Half-bridge gate driver for the SWIPT inverter. The PLL2 frequency word is converted
// to a half-period cycle count, which drives complementary gates separated by dead time.
module pll_gate_driver #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned F_MIN    = 26000,
    parameter int unsigned F_MAX    = 56000,
    parameter int unsigned DEAD_CYC = 20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic        en,
    input  logic [31:0] f,
    output logic        gate_a,
    output logic        gate_b,
    output logic        drive_on,
    output logic [31:0] half_period,
    output logic        div_busy,
    output logic        clamped
);

    localparam int unsigned HP_RST = CLK_HZ / (2 * F_MIN);

    typedef enum logic [1:0] {D_IDLE, D_LOAD, D_DIV, D_DONE} div_state_t;
    typedef enum logic [2:0] {S_OFF, S_A_ON, S_DEAD_A, S_B_ON, S_DEAD_B} drv_state_t;

    div_state_t  div_state;
    drv_state_t  drv_state;
    logic [31:0] last_f;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [4:0]  bit_cnt;
    logic [31:0] pending;
    logic [31:0] phase_cnt;
    logic        stop_req;

    logic [31:0] f_clamp_c;
    logic [32:0] rem_sh_c;
    logic        rem_ge_c;
    logic [31:0] rem_next_c;
    logic [31:0] hp_src_c;

    // Clamp; f=0 lands on F_MIN so the divisor is never zero
    always_comb begin
        f_clamp_c = f;
        if (f < 32'(F_MIN))
            f_clamp_c = 32'(F_MIN);
        else if (f > 32'(F_MAX))
            f_clamp_c = 32'(F_MAX);
    end

    // One restoring division step
    always_comb begin
        rem_sh_c   = {rem, quo[31]};
        rem_ge_c   = (rem_sh_c >= {1'b0, divisor});
        rem_next_c = rem_ge_c ? 32'(rem_sh_c - {1'b0, divisor}) : rem_sh_c[31:0];
        hp_src_c   = (div_state == D_DONE) ? quo : pending;
    end

    // Divider: samples f when idle, computes CLK_HZ/(2*fc) in 32 steps
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_state <= D_IDLE;
            last_f    <= 32'd0;
            divisor   <= 32'd0;
            quo       <= 32'd0;
            rem       <= 32'd0;
            bit_cnt   <= 5'd0;
            pending   <= 32'(HP_RST);
            div_busy  <= 1'b0;
            clamped   <= 1'b0;
        end else begin
            case (div_state)
                D_IDLE: begin
                    if (f != last_f) begin
                        last_f    <= f;
                        divisor   <= f_clamp_c << 1;
                        clamped   <= (f != f_clamp_c);
                        div_busy  <= 1'b1;
                        div_state <= D_LOAD;
                    end
                end
                D_LOAD: begin
                    quo       <= 32'(CLK_HZ);
                    rem       <= 32'd0;
                    bit_cnt   <= 5'd31;
                    div_state <= D_DIV;
                end
                D_DIV: begin
                    rem <= rem_next_c;
                    quo <= {quo[30:0], rem_ge_c};
                    if (bit_cnt == 5'd0)
                        div_state <= D_DONE;
                    else
                        bit_cnt <= bit_cnt - 5'd1;
                end
                D_DONE: begin
                    pending   <= quo;
                    div_busy  <= 1'b0;
                    div_state <= D_IDLE;
                end
                default: div_state <= D_IDLE;
            endcase
        end
    end

    // Drive FSM; gates are registered from the state being entered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drv_state   <= S_OFF;
            phase_cnt   <= 32'd0;
            gate_a      <= 1'b0;
            gate_b      <= 1'b0;
            drive_on    <= 1'b0;
            half_period <= 32'(HP_RST);
            stop_req    <= 1'b0;
        end else if (!swiptAlive) begin
            drv_state <= S_OFF;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            drive_on  <= 1'b0;
            stop_req  <= 1'b0;
        end else begin
            if (!en && drv_state != S_OFF)
                stop_req <= 1'b1;
            case (drv_state)
                S_OFF: begin
                    stop_req <= 1'b0;
                    if (en) begin
                        drv_state   <= S_A_ON;
                        half_period <= hp_src_c;
                        phase_cnt   <= hp_src_c - 32'(DEAD_CYC) - 32'd1;
                        gate_a      <= 1'b1;
                        drive_on    <= 1'b1;
                    end
                end
                S_A_ON, S_B_ON: begin
                    if (phase_cnt == 32'd0) begin
                        drv_state <= (drv_state == S_A_ON) ? S_DEAD_A : S_DEAD_B;
                        phase_cnt <= 32'(DEAD_CYC) - 32'd1;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 32'd1;
                    end
                end
                S_DEAD_A, S_DEAD_B: begin
                    if (phase_cnt != 32'd0) begin
                        phase_cnt <= phase_cnt - 32'd1;
                    end else if (stop_req || !en) begin
                        drv_state <= S_OFF;
                        drive_on  <= 1'b0;
                    end else if (drv_state == S_DEAD_A) begin
                        drv_state <= S_B_ON;
                        phase_cnt <= half_period - 32'(DEAD_CYC) - 32'd1;
                        gate_b    <= 1'b1;
                    end else begin
                        drv_state   <= S_A_ON;
                        half_period <= hp_src_c;
                        phase_cnt   <= hp_src_c - 32'(DEAD_CYC) - 32'd1;
                        gate_a      <= 1'b1;
                    end
                end
                default: begin
                    drv_state <= S_OFF;
                    gate_a    <= 1'b0;
                    gate_b    <= 1'b0;
                    drive_on  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_gate_driver.sv
// Directed bench for pll_gate_driver: periods, clamping, retune, stop rules, reset.
module tb_pll_gate_driver;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swipt_alive;
    logic        en;
    logic [31:0] f;
    logic        gate_a;
    logic        gate_b;
    logic        drive_on;
    logic [31:0] half_period;
    logic        div_busy;
    logic        clamped;

    int total = 0;
    int bad   = 0;

    pll_gate_driver dut (
        .clk(clk), .nrst(nrst), .swiptAlive(swipt_alive), .en(en), .f(f),
        .gate_a(gate_a), .gate_b(gate_b), .drive_on(drive_on),
        .half_period(half_period), .div_busy(div_busy), .clamped(clamped)
    );

    always #5 clk = ~clk;

    // Gates must never overlap on any cycle
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            total++;
            if (gate_a & gate_b) begin
                bad++;
                $display("FAIL overlap at %0t: gate_a=%b gate_b=%b required not both 1", $time, gate_a, gate_b);
            end
        end
    end

    function automatic logic cond(input int which);
        case (which)
            0: return gate_a === 1'b1;
            1: return gate_a === 1'b0 && gate_b === 1'b0;
            2: return gate_b === 1'b1;
            3: return div_busy === 1'b1;
            default: return gate_a === 1'b0 && gate_b === 1'b0 && drive_on === 1'b1;
        endcase
    endfunction

    // Count consecutive negedges on which the condition holds (bounded)
    task automatic run_len(input int which, output int n);
        n = 0;
        while (cond(which) && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_for(input int which, input int bound, output logic ok);
        int k = 0;
        while (!cond(which) && k < bound) begin
            k++;
            @(negedge clk);
        end
        ok = cond(which);
    endtask

    task automatic wait_div(output logic ok);
        logic ok1;
        wait_for(3, 10, ok1);
        while (div_busy === 1'b1 && ok1) begin
            int k;
            run_len(3, k);
        end
        ok = ok1 && (div_busy === 1'b0);
    endtask

    task automatic test_reset;
        nrst = 1'b0; en = 1'b0; swipt_alive = 1'b0; f = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({gate_a, gate_b, drive_on, div_busy, clamped} !== 5'b0 || half_period !== 32'd1923) begin
            bad++;
            $display("FAIL reset: ga=%b gb=%b on=%b busy=%b cl=%b hp=%0d required 0s hp=1923",
                     gate_a, gate_b, drive_on, div_busy, clamped, half_period);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic ok;
        int   a, d1, b, d2;
        f = 32'd41000;
        wait_div(ok);
        en = 1'b1; swipt_alive = 1'b1;
        wait_for(0, 10, ok);
        total++;
        if (!ok || half_period !== 32'd1219 || clamped !== 1'b0) begin
            bad++;
            $display("FAIL basic_start: ok=%b hp=%0d cl=%b required hp=1219 cl=0", ok, half_period, clamped);
        end
        run_len(0, a); run_len(1, d1); run_len(2, b); run_len(1, d2);
        total++;
        if (a != 1199 || b != 1199) begin
            bad++;
            $display("FAIL basic_on: a=%0d b=%0d required 1199", a, b);
        end
        total++;
        if (d1 != 20 || d2 != 20) begin
            bad++;
            $display("FAIL basic_dead: d1=%0d d2=%0d required 20", d1, d2);
        end
        total++;
        if (a + d1 + b + d2 != 2438 || gate_a !== 1'b1) begin
            bad++;
            $display("FAIL basic_period: period=%0d ga=%b required 2438 ga=1", a + d1 + b + d2, gate_a);
        end
    endtask

    task automatic test_clamp;
        logic [31:0] fv [3] = '{32'd10000, 32'd90000, 32'd0};
        logic [31:0] hv [3] = '{32'd1923, 32'd892, 32'd1923};
        logic ok;
        for (int i = 0; i < 3; i++) begin
            swipt_alive = 1'b0;
            @(negedge clk);
            f = fv[i];
            wait_div(ok);
            swipt_alive = 1'b1;
            wait_for(0, 10, ok);
            total++;
            if (!ok || half_period !== hv[i] || clamped !== 1'b1) begin
                bad++;
                $display("FAIL clamp f=%0d: ok=%b hp=%0d cl=%b required hp=%0d cl=1",
                         fv[i], ok, half_period, clamped, hv[i]);
            end
        end
    endtask

    task automatic test_retune;
        logic ok;
        int   busy, rest, d1, a, d2, b, d3;
        swipt_alive = 1'b0;
        @(negedge clk);
        f = 32'd41000;
        wait_div(ok);
        swipt_alive = 1'b1;
        wait_for(2, 3000, ok);
        repeat (100) @(negedge clk);
        f = 32'd50000;
        @(negedge clk);
        run_len(3, busy);
        total++;
        if (busy != 34) begin
            bad++;
            $display("FAIL retune_busy: cycles=%0d required 34", busy);
        end
        total++;
        if (half_period !== 32'd1219 || gate_b !== 1'b1) begin
            bad++;
            $display("FAIL retune_hold: hp=%0d gb=%b required 1219 gb=1", half_period, gate_b);
        end
        run_len(2, rest); run_len(1, d1);
        total++;
        if (rest != 1064 || d1 != 20) begin
            bad++;
            $display("FAIL retune_old_tail: rest=%0d dead=%0d required 1064 20", rest, d1);
        end
        total++;
        if (half_period !== 32'd1000 || gate_a !== 1'b1) begin
            bad++;
            $display("FAIL retune_new_hp: hp=%0d ga=%b required 1000 ga=1", half_period, gate_a);
        end
        run_len(0, a); run_len(1, d2); run_len(2, b); run_len(1, d3);
        total++;
        if (a != 980 || b != 980 || a + d2 + b + d3 != 2000) begin
            bad++;
            $display("FAIL retune_period: a=%0d b=%0d period=%0d required 980 980 2000", a, b, a + d2 + b + d3);
        end
    endtask

    task automatic test_alive_drop;
        logic ok;
        wait_for(0, 3000, ok);
        repeat (50) @(negedge clk);
        swipt_alive = 1'b0;
        @(negedge clk);
        total++;
        if (gate_a !== 1'b0 || gate_b !== 1'b0 || drive_on !== 1'b0) begin
            bad++;
            $display("FAIL alive_stop: ga=%b gb=%b on=%b required 0 0 0", gate_a, gate_b, drive_on);
        end
        repeat (5) @(negedge clk);
        swipt_alive = 1'b1;
        @(negedge clk);
        total++;
        if (gate_a !== 1'b1 || drive_on !== 1'b1 || half_period !== 32'd1000) begin
            bad++;
            $display("FAIL alive_restart: ga=%b on=%b hp=%0d required 1 1 1000", gate_a, drive_on, half_period);
        end
    endtask

    task automatic test_en_stop;
        int n = 0;
        int d, seen = 0;
        while (gate_a === 1'b1 && n < 5000) begin
            if (n == 100) en = 1'b0;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 980) begin
            bad++;
            $display("FAIL en_stop_on: a=%0d required 980", n);
        end
        run_len(4, d);
        total++;
        if (d != 20 || drive_on !== 1'b0) begin
            bad++;
            $display("FAIL en_stop_dead: dead=%0d on=%b required 20 0", d, drive_on);
        end
        repeat (2500) begin
            @(negedge clk);
            if (gate_a === 1'b1 || gate_b === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL en_stop_quiet: active cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int a, d1, b, d2;
        en = 1'b1;
        f = 32'd41000;
        repeat (10) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        total++;
        if ({gate_a, gate_b, drive_on, div_busy, clamped} !== 5'b0 || half_period !== 32'd1923) begin
            bad++;
            $display("FAIL reset_async: ga=%b gb=%b on=%b busy=%b cl=%b hp=%0d required 0s hp=1923",
                     gate_a, gate_b, drive_on, div_busy, clamped, half_period);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b1 || gate_a !== 1'b1 || drive_on !== 1'b1 || half_period !== 32'd1923) begin
            bad++;
            $display("FAIL reset_resume: busy=%b ga=%b on=%b hp=%0d required 1 1 1 1923",
                     div_busy, gate_a, drive_on, half_period);
        end
        run_len(0, a); run_len(1, d1); run_len(2, b); run_len(1, d2);
        total++;
        if (a != 1903 || b != 1903 || d1 != 20 || d2 != 20 || half_period !== 32'd1219) begin
            bad++;
            $display("FAIL reset_periods: a=%0d d=%0d b=%0d d=%0d hp=%0d required 1903 20 1903 20 1219",
                     a, d1, b, d2, half_period);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_retune();
        test_alive_drop();
        test_en_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
